serial_comparator: RTL and testbench
====================================

// Module: serial_comparator
// PURPOSE
//  Parametrised multi-cycle magnitude comparator; successor to the 8-bit combinational
//  comparator. Compares two WIDTH-bit operands DIGIT bits per cycle, MSB chunk first,
//  stopping early at the first differing chunk. Supports unsigned and two's-complement
//  modes and uses a start/busy/done handshake so it fits in multi-cycle datapaths.
// PARAMETERS
//  WIDTH      16  operand width in bits; must be >= 2
//  DIGIT      4   bits compared per cycle; must divide WIDTH exactly
//  SIGNED_EN  1   1 = signed_mode input honoured; 0 = always unsigned (signed_mode ignored)
// PORTS
//  clock        input   1          system clock, all logic on rising edge
//  reset_n      input   1          synchronous reset, active low
//  start        input   1          request a compare; sampled only when busy=0
//  signed_mode  input   1          1 = treat a, b as two's complement; sampled with start
//  a            input   WIDTH      operand A; sampled with start
//  b            input   WIDTH      operand B; sampled with start
//  busy         output  1          high while a compare is in progress
//  done         output  1          single-cycle pulse when result is valid
//  a_lt_b       output  1          registered result: A < B
//  a_gt_b       output  1          registered result: A > B
//  a_eq_b       output  1          registered result: A == B
//  cycles       output  CW         chunks examined in last compare, CW = $clog2(WIDTH/DIGIT+1)
// BEHAVIOUR
//  - Reset (reset_n=0 at a clock edge): state IDLE; busy, done, a_lt_b, a_gt_b, a_eq_b,
//    cycles all 0; shift registers cleared. Reset mid-compare aborts; no done pulse.
//  - States: IDLE -> COMPARE on start=1. COMPARE -> IDLE when a chunk differs or the
//    last chunk (index N-1, N=WIDTH/DIGIT) is evaluated. No other transitions.
//  - Capture (IDLE, start=1): latch a, b into shift registers; if signed_mode & SIGNED_EN,
//    invert the MSB of both (offset-binary), so unsigned compare gives signed order.
//    Clear all three result flags and cycles; busy=1 from the next cycle.
//  - COMPARE: each cycle compare top DIGIT bits of both registers; chunk counter k
//    counts from 0 at the MSB chunk.
//    * chunks differ: set a_lt_b or a_gt_b per chunk magnitude; cycles=k+1.
//    * equal and k<N-1: shift both left by DIGIT, k++.
//    * equal and k=N-1: set a_eq_b; cycles=N.
//    On deciding edge: done=1 for exactly one cycle, busy=0 in the same cycle.
//  - Latency: with start sampled at edge E0, done is high after edge E(k+1) where k is the
//    first differing chunk; worst case N cycles (equal operands). Next start is accepted
//    on the edge where done is high (busy=0), giving back-to-back throughput.
//  - start while busy=1: ignored; a, b, signed_mode changes have no effect mid-compare.
//  - Result flags and cycles hold after done until the next accepted start. From then on
//    exactly one flag is high; all flags are 0 while busy and after reset.
//  - Arithmetic: chunk compare is unsigned DIGIT-bit; no carry chain across WIDTH.
// TESTING
//  Default params unless noted; latencies are counted from the edge that samples start.
//  1. reset, a=16'h0000 b=16'h0000 start -> done after 4 cycles, eq=1 lt=0 gt=0, cycles=4.
//  2. a=16'h1234 b=16'h1235 unsigned -> lt=1, cycles=4; a=16'h1334 b=16'h1235 -> gt=1, cycles=2.
//  3. a=16'h9000 b=16'h1000: signed_mode=0 -> gt=1 cycles=1; signed_mode=1 -> lt=1 cycles=1;
//     SIGNED_EN=0 with signed_mode=1 -> gt=1.
//  4. signed a=16'hFFFF(-1) b=16'h0001 -> lt=1, cycles=1; a=b=16'h8000 -> eq=1, cycles=4.
//  5. start held high with new operands during busy -> ignored, first result reported;
//     start on done cycle -> accepted, second compare completes with correct flags.
//  6. reset_n=0 during cycle 2 of compare -> busy=0, flags=0, no done pulse. Regression:
//     WIDTH=8 DIGIT=1 with 0/0, 10/12, 9/3, 7/7, 21/42 -> eq, lt, gt, eq, lt.

Source files
------------

// File: rtl/serial_comparator_if.sv
// Handshake and operand/result bundle for the multi-cycle serial magnitude comparator.
// CW must equal $clog2(WIDTH/DIGIT+1) of the attached comparator.
interface serial_comparator_if #(
    parameter int WIDTH = 16,
    parameter int CW    = 3
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             a_lt_b;
    logic             a_gt_b;
    logic             a_eq_b;
    logic [CW-1:0]    cycles;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, a_lt_b, a_gt_b, a_eq_b, cycles
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, a_lt_b, a_gt_b, a_eq_b, cycles
    );
endinterface

// File: rtl/serial_comparator.sv
// Multi-cycle magnitude comparator: walks both operands DIGIT bits per cycle from the
// MSB chunk down and stops at the first differing chunk; signed order via MSB flip.
module serial_comparator #(
    parameter int WIDTH     = 16,
    parameter int DIGIT     = 4,
    parameter int SIGNED_EN = 1
) (
    input logic           clock,
    input logic           reset_n,
    serial_comparator_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COMPARE = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] sh_a_r;
    logic [WIDTH-1:0] sh_b_r;
    logic [CW-1:0]    k_r;
    logic [CW-1:0]    cycles_r;
    logic             busy_r;
    logic             done_r;
    logic             lt_r;
    logic             gt_r;
    logic             eq_r;

    logic [DIGIT-1:0] chunk_a_s;
    logic [DIGIT-1:0] chunk_b_s;
    logic             differ_s;
    logic             last_s;
    logic             capture_s;
    logic             shift_s;
    logic             decide_s;
    logic [WIDTH-1:0] msb_flip_s;

    assign chunk_a_s = sh_a_r[WIDTH-1 -: DIGIT];
    assign chunk_b_s = sh_b_r[WIDTH-1 -: DIGIT];
    assign differ_s  = (chunk_a_s != chunk_b_s);
    assign last_s    = (k_r == CW'(N - 1));

    // Offset-binary mask: flipping both MSBs turns signed order into unsigned order
    always_comb begin
        msb_flip_s = {WIDTH{1'b0}};
        if ((SIGNED_EN != 0) && bus.signed_mode) begin
            msb_flip_s[WIDTH-1] = 1'b1;
        end else begin
            msb_flip_s[WIDTH-1] = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_s = COMPARE;
                end else begin
                    state_s = IDLE;
                end
            end
            COMPARE: begin
                if (differ_s || last_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = COMPARE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Datapath control strobes decoded from the current state
    always_comb begin
        capture_s = 1'b0;
        shift_s   = 1'b0;
        decide_s  = 1'b0;
        case (state_r)
            IDLE: begin
                capture_s = bus.start;
            end
            COMPARE: begin
                if (differ_s || last_s) begin
                    decide_s = 1'b1;
                end else begin
                    shift_s = 1'b1;
                end
            end
            default: begin
                capture_s = 1'b0;
            end
        endcase
    end

    // Operand shifters, chunk counter and registered results
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sh_a_r   <= {WIDTH{1'b0}};
            sh_b_r   <= {WIDTH{1'b0}};
            k_r      <= {CW{1'b0}};
            cycles_r <= {CW{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            lt_r     <= 1'b0;
            gt_r     <= 1'b0;
            eq_r     <= 1'b0;
        end else begin
            done_r <= decide_s;
            if (capture_s) begin
                sh_a_r   <= bus.a ^ msb_flip_s;
                sh_b_r   <= bus.b ^ msb_flip_s;
                k_r      <= {CW{1'b0}};
                cycles_r <= {CW{1'b0}};
                busy_r   <= 1'b1;
                lt_r     <= 1'b0;
                gt_r     <= 1'b0;
                eq_r     <= 1'b0;
            end else if (shift_s) begin
                sh_a_r <= sh_a_r << DIGIT;
                sh_b_r <= sh_b_r << DIGIT;
                k_r    <= k_r + CW'(1);
            end else if (decide_s) begin
                // k+1 equals N when the run reaches the last chunk
                busy_r   <= 1'b0;
                cycles_r <= k_r + CW'(1);
                lt_r     <= differ_s && (chunk_a_s < chunk_b_s);
                gt_r     <= differ_s && (chunk_a_s > chunk_b_s);
                eq_r     <= !differ_s;
            end
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.a_lt_b = lt_r;
    assign bus.a_gt_b = gt_r;
    assign bus.a_eq_b = eq_r;
    assign bus.cycles = cycles_r;
endmodule

// File: tb/tb_serial_comparator.sv
// Scoreboard bench for serial_comparator: default, SIGNED_EN=0 and WIDTH=8/DIGIT=1 instances.
module tb_serial_comparator;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   edge_cnt = 0;
    int   checks = 0;
    int   failures = 0;

    localparam logic [2:0] LT = 3'b100;
    localparam logic [2:0] GT = 3'b010;
    localparam logic [2:0] EQ = 3'b001;

    typedef struct {
        logic [2:0] flags;
        int         cyc;
        int         edge_n;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    serial_comparator_if #(.WIDTH(16), .CW(3)) m ();
    serial_comparator_if #(.WIDTH(16), .CW(3)) n ();
    serial_comparator_if #(.WIDTH(8),  .CW(4)) w ();

    serial_comparator #(.WIDTH(16), .DIGIT(4), .SIGNED_EN(1)) u_main (
        .clock(clock), .reset_n(reset_n), .bus(m.slave));
    serial_comparator #(.WIDTH(16), .DIGIT(4), .SIGNED_EN(0)) u_nosign (
        .clock(clock), .reset_n(reset_n), .bus(n.slave));
    serial_comparator #(.WIDTH(8), .DIGIT(1), .SIGNED_EN(1)) u_w8 (
        .clock(clock), .reset_n(reset_n), .bus(w.slave));

    always #5 clock = ~clock;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input int id, input logic [15:0] av, input logic [15:0] bv,
                          input logic sm, input logic st);
        case (id)
            0: begin m.a = av; m.b = bv; m.signed_mode = sm; m.start = st; end
            1: begin n.a = av; n.b = bv; n.signed_mode = sm; n.start = st; end
            default: begin w.a = av[7:0]; w.b = bv[7:0]; w.signed_mode = sm; w.start = st; end
        endcase
    endtask

    function automatic logic get_done(input int id);
        case (id)
            0: return m.done;
            1: return n.done;
            default: return w.done;
        endcase
    endfunction

    task automatic push(input int id, input logic [2:0] flags, input int cyc);
        exp_t e;
        e.flags  = flags;
        e.cyc    = cyc;
        e.edge_n = edge_cnt + 1 + cyc;
        case (id)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic check_done(input int id, input logic [2:0] flags, input int cyc,
                              input logic busy);
        exp_t e;
        logic empty;
        empty = 1'b0;
        case (id)
            0: if (q0.size() == 0) empty = 1'b1; else e = q0.pop_front();
            1: if (q1.size() == 0) empty = 1'b1; else e = q1.pop_front();
            default: if (q2.size() == 0) empty = 1'b1; else e = q2.pop_front();
        endcase
        if (empty) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done dut=%0d actual=done expected=no_done (t=%0t)", id, $time);
        end else begin
            chk($sformatf("flags_d%0d", id), int'(flags), int'(e.flags));
            chk($sformatf("cycles_d%0d", id), cyc, e.cyc);
            chk($sformatf("latency_edge_d%0d", id), edge_cnt, e.edge_n);
            chk($sformatf("busy_at_done_d%0d", id), int'(busy), 0);
        end
    endtask

    // Monitors: pop and compare whenever a DUT pulses done
    always @(negedge clock) begin
        if (m.done) check_done(0, {m.a_lt_b, m.a_gt_b, m.a_eq_b}, int'(m.cycles), m.busy);
        if (n.done) check_done(1, {n.a_lt_b, n.a_gt_b, n.a_eq_b}, int'(n.cycles), n.busy);
        if (w.done) check_done(2, {w.a_lt_b, w.a_gt_b, w.a_eq_b}, int'(w.cycles), w.busy);
        if (reset_n && m.busy) chk("flags_zero_while_busy", int'({m.a_lt_b, m.a_gt_b, m.a_eq_b}), 0);
    end

    task automatic wait_done(input int id);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            if (get_done(id)) seen = 1'b1;
            else @(negedge clock);
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL timeout_done dut=%0d actual=no_done expected=done", id);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is visible
    task automatic run(input int id, input logic [15:0] av, input logic [15:0] bv,
                       input logic sm, input logic [2:0] flags, input int cyc);
        set_in(id, av, bv, sm, 1'b1);
        push(id, flags, cyc);
        @(posedge clock);
        @(negedge clock);
        set_in(id, av, bv, sm, 1'b0);
        wait_done(id);
    endtask

    initial begin
        set_in(0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        set_in(1, 16'h0000, 16'h0000, 1'b0, 1'b0);
        set_in(2, 16'h0000, 16'h0000, 1'b0, 1'b0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_busy", int'(m.busy), 0);
        chk("reset_done", int'(m.done), 0);
        chk("reset_flags", int'({m.a_lt_b, m.a_gt_b, m.a_eq_b}), 0);
        chk("reset_cycles", int'(m.cycles), 0);
        chk("reset_flags_w8", int'({w.a_lt_b, w.a_gt_b, w.a_eq_b}), 0);
        reset_n = 1'b1;
        @(negedge clock);

        // Default instance: unsigned and signed directed vectors
        run(0, 16'h0000, 16'h0000, 1'b0, EQ, 4);
        run(0, 16'h1234, 16'h1235, 1'b0, LT, 4);
        run(0, 16'h1334, 16'h1235, 1'b0, GT, 2);
        run(0, 16'h9000, 16'h1000, 1'b0, GT, 1);
        run(0, 16'h9000, 16'h1000, 1'b1, LT, 1);
        run(0, 16'hFFFF, 16'h0001, 1'b1, LT, 1);
        run(0, 16'h8000, 16'h8000, 1'b1, EQ, 4);
        run(0, 16'h7FFF, 16'h8000, 1'b1, GT, 1);
        chk("hold_after_done_eq", int'({m.a_lt_b, m.a_gt_b, m.a_eq_b}), int'(GT));
        @(negedge clock);
        chk("hold_next_cycle", int'({m.a_lt_b, m.a_gt_b, m.a_eq_b}), int'(GT));
        chk("hold_cycles", int'(m.cycles), 1);

        // Signed mode ignored when SIGNED_EN=0
        run(1, 16'h9000, 16'h1000, 1'b1, GT, 1);
        run(1, 16'hFFFF, 16'h0001, 1'b1, GT, 1);

        // WIDTH=8 DIGIT=1 regression
        run(2, 16'd0,  16'd0,  1'b0, EQ, 8);
        run(2, 16'd10, 16'd12, 1'b0, LT, 6);
        run(2, 16'd9,  16'd3,  1'b0, GT, 5);
        run(2, 16'd7,  16'd7,  1'b0, EQ, 8);
        run(2, 16'd21, 16'd42, 1'b0, LT, 3);

        // start held during busy is ignored; start on the done cycle is accepted
        @(negedge clock);
        set_in(0, 16'h1234, 16'h1235, 1'b0, 1'b1);
        push(0, LT, 4);
        @(posedge clock);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge clock);
                if (m.done) seen = 1'b1;
                else set_in(0, 16'hFFFF, 16'h0000, 1'b1, 1'b1);
            end
            chk("busy_hold_done_seen", int'(seen), 1);
        end
        set_in(0, 16'h0005, 16'h0003, 1'b0, 1'b1);
        push(0, GT, 4);
        @(posedge clock);
        @(negedge clock);
        chk("b2b_busy", int'(m.busy), 1);
        set_in(0, 16'h0005, 16'h0003, 1'b0, 1'b0);
        wait_done(0);

        // Reset in the second compare cycle aborts with no done pulse
        @(negedge clock);
        set_in(0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        @(posedge clock);
        @(negedge clock);
        set_in(0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        @(posedge clock);
        @(negedge clock);
        chk("abort_busy_before", int'(m.busy), 1);
        reset_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("abort_busy", int'(m.busy), 0);
        chk("abort_done", int'(m.done), 0);
        chk("abort_flags", int'({m.a_lt_b, m.a_gt_b, m.a_eq_b}), 0);
        chk("abort_cycles", int'(m.cycles), 0);
        reset_n = 1'b1;
        repeat (10) @(negedge clock);

        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);
        chk("q2_empty", q2.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
